// File: rtl/mod_addsub_ctrl_if.sv
// Request-side and adder-side bundles for the modular add/subtract controller.
// master drives the request (or the adder controls); slave answers.
interface mod_addsub_req_if #(parameter int WIDTH = 384);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_p;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport master (output start, op, in_a, in_b, in_p, input result, done, busy);
  modport slave  (input start, op, in_a, in_b, in_p, output result, done, busy);
endinterface

interface mod_addsub_add_if #(parameter int WIDTH = 384);
  logic             add_start;
  logic             add_subtract;
  logic [WIDTH-1:0] add_in_a;
  logic [WIDTH-1:0] add_in_b;
  logic [WIDTH:0]   add_result;
  logic             add_done;

  modport master (output add_start, add_subtract, add_in_a, add_in_b,
                  input add_result, add_done);
  modport slave  (input add_start, add_subtract, add_in_a, add_in_b,
                  output add_result, add_done);
endinterface

// File: rtl/mod_addsub_ctrl.sv
// Sequences one or two passes through the shared wide adder to compute
// (a +/- b) mod p, then reports the reduced value with a done pulse.
module mod_addsub_ctrl #(
  parameter int WIDTH = 384
) (
  input  logic             clk,
  input  logic             reset,
  mod_addsub_req_if.slave  req,
  mod_addsub_add_if.master add
);

  typedef enum logic [2:0] {
    IDLE, S1_GO, S1_WAIT, S2_GO, S2_WAIT, FIN
  } state_t;

  state_t           r_state, w_next;
  logic             r_op;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH:0]   r_t;
  logic [WIDTH-1:0] r_result;
  logic             r_add_sub;
  logic [WIDTH-1:0] r_add_a;
  logic [WIDTH-1:0] r_add_b;
  logic             w_borrow;

  assign w_borrow = add.add_result[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Wait states are entered only from a GO state, so a done level left over
  // from the previous pass is never sampled alongside the fresh start pulse.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (req.start) w_next = S1_GO;
      S1_GO:   w_next = S1_WAIT;
      S1_WAIT: if (add.add_done) w_next = (r_op && !w_borrow) ? FIN : S2_GO;
      S2_GO:   w_next = S2_WAIT;
      S2_WAIT: if (add.add_done) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The adder operand registers double as the latched A and B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= 1'b0;
      r_p       <= '0;
      r_t       <= '0;
      r_result  <= '0;
      r_add_sub <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
    end else begin
      case (r_state)
        IDLE: if (req.start) begin
          r_op      <= req.op;
          r_p       <= req.in_p;
          r_t       <= '0;
          r_add_sub <= req.op;
          r_add_a   <= req.in_a;
          r_add_b   <= req.in_b;
        end
        S1_WAIT: if (add.add_done) begin
          r_t <= add.add_result;
          if (r_op && !w_borrow) begin
            r_result <= add.add_result[WIDTH-1:0];
          end else begin
            // add: try T - p; subtract with borrow: T + p
            r_add_sub <= ~r_op;
            r_add_a   <= add.add_result[WIDTH-1:0];
            r_add_b   <= r_p;
          end
        end
        S2_WAIT: if (add.add_done) begin
          if (r_op || r_t[WIDTH] || !w_borrow) r_result <= add.add_result[WIDTH-1:0];
          else                                 r_result <= r_t[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign add.add_start    = (r_state == S1_GO) || (r_state == S2_GO);
  assign add.add_subtract = r_add_sub;
  assign add.add_in_a     = r_add_a;
  assign add.add_in_b     = r_add_b;
  assign req.result       = r_result;
  assign req.done         = (r_state == FIN);
  assign req.busy         = (r_state != IDLE);

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Scoreboard bench for mod_addsub_ctrl with a behavioural multi-cycle adder
// (configurable latency, pulse or level done).
module tb_mod_addsub_ctrl;
  localparam int W = 384;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mod_addsub_req_if #(.WIDTH(W)) rq();
  mod_addsub_add_if #(.WIDTH(W)) ad();

  mod_addsub_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .req(rq), .add(ad));

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // behavioural adder: result shows up only together with done
  int       alat = 4;
  bit       level_mode = 1'b1;
  int       acnt;
  logic [W:0] ares;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acnt <= 0; ares <= '0;
      ad.add_done <= 1'b0; ad.add_result <= '0;
    end else if (ad.add_start) begin
      acnt <= alat;
      ad.add_done <= 1'b0;
      ad.add_result <= '0;
      ares <= ad.add_subtract ? ({1'b0, ad.add_in_a} - {1'b0, ad.add_in_b})
                              : ({1'b0, ad.add_in_a} + {1'b0, ad.add_in_b});
    end else if (acnt > 0) begin
      acnt <= acnt - 1;
      if (acnt == 1) begin
        ad.add_done <= 1'b1;
        ad.add_result <= ares;
      end
    end else if (!level_mode) begin
      ad.add_done <= 1'b0;
    end
  end

  typedef struct {
    logic [W-1:0] res;
    int           nst;
    int           t0;
  } exp_t;
  exp_t q[$];

  int nst_seen = 0;
  int lat1 = 0, lat2 = 0;
  always @(negedge clk) begin
    if (reset) nst_seen = 0;
    else begin
      if (ad.add_start) nst_seen = nst_seen + 1;
      if (rq.done) begin
        nchk = nchk + 1;
        if (q.size() == 0) begin
          nfail = nfail + 1;
          $display("FAIL unexpected_done: result=%0h, no request pending", rq.result);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (rq.result !== e.res) begin
            nfail = nfail + 1;
            $display("FAIL result: got %0h expected %0h", rq.result, e.res);
          end
          nchk = nchk + 1;
          if (nst_seen != e.nst) begin
            nfail = nfail + 1;
            $display("FAIL add_start_count: got %0d expected %0d", nst_seen, e.nst);
          end
          if (e.nst == 1) lat1 = cyc - e.t0;
          else            lat2 = cyc - e.t0;
        end
        nst_seen = 0;
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    nchk = nchk + 1;
    if (got !== exp) begin
      nfail = nfail + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] p, input bit push,
                       input logic [W-1:0] res, input int nst);
    exp_t e;
    @(negedge clk);
    rq.start = 1'b1; rq.op = op; rq.in_a = a; rq.in_b = b; rq.in_p = p;
    @(posedge clk); #1;
    if (push) begin
      e.res = res; e.nst = nst; e.t0 = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    rq.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rq.done) seen = 1'b1;
    end
    if (!seen) begin
      nchk = nchk + 1; nfail = nfail + 1;
      $display("FAIL timeout_%s: done not seen, required within 300 cycles", name);
    end
    @(posedge clk); #1;
  endtask

  task automatic run(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] p, input logic [W-1:0] res, input int nst,
                     input string name);
    issue(op, a, b, p, 1'b1, res, nst);
    wait_done(name);
  endtask

  logic [W-1:0] P13, PMAX;

  initial begin
    P13 = W'(13);
    PMAX = {W{1'b1}};
    rq.start = 1'b0; rq.op = 1'b0; rq.in_a = '0; rq.in_b = '0; rq.in_p = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy",      W'(rq.busy), '0);
    check("reset_done",      W'(rq.done), '0);
    check("reset_add_start", W'(ad.add_start), '0);
    check("reset_result",    rq.result, '0);
    check("reset_add_in_a",  ad.add_in_a, '0);
    @(negedge clk) reset = 1'b0;

    level_mode = 1'b1; alat = 4;
    run(1'b0, W'(7), W'(9), P13, W'(3), 2, "add_7_9");
    run(1'b0, W'(6), W'(7), P13, W'(0), 2, "add_eq_p");
    run(1'b1, W'(3), W'(5), P13, W'(11), 2, "sub_borrow");
    run(1'b1, W'(5), W'(3), P13, W'(2), 1, "sub_noborrow");
    nchk = nchk + 1;
    if (!(lat1 < lat2)) begin
      nfail = nfail + 1;
      $display("FAIL latency_one_pass: got %0d cycles, required fewer than two-pass %0d", lat1, lat2);
    end

    level_mode = 1'b0; alat = 1;
    run(1'b0, PMAX - 1, PMAX - 1, PMAX, PMAX - 2, 2, "add_pmax");
    alat = 7;
    run(1'b1, W'(0), W'(12), P13, W'(1), 2, "sub_0_12_pulse");
    run(1'b0, W'(12), W'(0), P13, W'(12), 2, "add_12_0_pulse");
    // back-to-back: issue's first negedge is the cycle right after done
    alat = 2;
    issue(1'b1, W'(9), W'(4), P13, 1'b1, W'(5), 1);
    wait_done("sub_9_4");

    // second start mid-operation must be ignored
    level_mode = 1'b1; alat = 5;
    issue(1'b0, W'(7), W'(9), P13, 1'b1, W'(3), 2);
    repeat (3) @(negedge clk);
    rq.start = 1'b1; rq.op = 1'b1; rq.in_a = W'(1); rq.in_b = W'(2);
    @(negedge clk) rq.start = 1'b0;
    wait_done("ignore_start");
    check("result_hold", rq.result, W'(3));

    // reset while waiting on the first pass
    issue(1'b0, W'(1), W'(1), P13, 1'b0, '0, 0);
    @(negedge clk);
    check("s1wait_busy", W'(rq.busy), W'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_busy",      W'(rq.busy), '0);
    check("rst_mid_done",      W'(rq.done), '0);
    check("rst_mid_add_start", W'(ad.add_start), '0);
    check("rst_mid_result",    rq.result, '0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_no_done", W'(q.size()), '0);
    run(1'b0, W'(7), W'(9), P13, W'(3), 2, "after_reset");

    repeat (3) @(negedge clk);
    check("queue_drained", W'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
